// File: rtl/tft_bus_arbiter.sv
// tft_bus_arbiter
//   Shares one tft_spi transmitter among N_CH drawing clients. One client is
//   granted at a time through a one-hot enable. That client's data, dc and
//   transmit are muxed onto the SPI inputs. Arbitration is fixed priority
//   (MODE 0, ch0 highest) or round-robin (MODE 1).
//   Each grant runs the following sequence:
//     ARM   : waits for the client to raise busy, or times out.
//     RUN   : waits for the client to drop busy.
//     DRAIN : waits for the SPI to finish its last byte.
//   The bus is then released for at least one idle cycle.
//
// Ports
//   clk          system clock
//   rst          asynchronous reset, active-low
//   req          per-client bus request (level)
//   ch_busy      per-client busy
//   ch_data      client data, channel i at [i*DATA_W +: DATA_W]
//   ch_dc        per-client dc
//   ch_transmit  per-client transmit strobe
//   spi_busy     tft_spi busy
//   enable       one-hot grant / client enable
//   spi_data     muxed data to tft_spi
//   spi_dc       muxed dc
//   spi_transmit muxed transmit
//   grant_idx    index of the current or last grant
//   active       a grant is in progress
//   timeout      one-cycle pulse when the granted client never raised busy
module tft_bus_arbiter #(
  parameter int N_CH          = 3,
  parameter int DATA_W        = 8,
  parameter int MODE          = 0,
  parameter int START_TIMEOUT = 16,
  localparam int GW           = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CH-1:0]        req,
  input  logic [N_CH-1:0]        ch_busy,
  input  logic [N_CH*DATA_W-1:0] ch_data,
  input  logic [N_CH-1:0]        ch_dc,
  input  logic [N_CH-1:0]        ch_transmit,
  input  logic                   spi_busy,
  output logic [N_CH-1:0]        enable,
  output logic [DATA_W-1:0]      spi_data,
  output logic                   spi_dc,
  output logic                   spi_transmit,
  output logic [GW-1:0]          grant_idx,
  output logic                   active,
  output logic                   timeout
);

  localparam int CW = $clog2(START_TIMEOUT);

  typedef enum logic [1:0] {IDLE, ARM, RUN, DRAIN} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [GW-1:0]   rr_ptr;
  logic [GW-1:0]   win;
  logic            cur_busy;

  // First requester in priority order. In round-robin mode the search
  // starts at the pointer and wraps modulo N_CH.
  function automatic logic [GW-1:0] pick_winner(input logic [N_CH-1:0] r,
                                                input logic [GW-1:0]   ptr);
    logic [GW-1:0] w;
    logic          found;
    int            idx;
    w     = '0;
    found = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      idx = (MODE == 1) ? ((int'(ptr) + k) % N_CH) : k;
      if (!found && r[idx]) begin
        found = 1'b1;
        w     = GW'(idx);
      end
    end
    return w;
  endfunction

  function automatic logic [N_CH-1:0] onehot(input logic [GW-1:0] w);
    logic [N_CH-1:0] o;
    for (int i = 0; i < N_CH; i++) o[i] = (GW'(i) == w);
    return o;
  endfunction

  function automatic logic [GW-1:0] next_idx(input logic [GW-1:0] w);
    return (w == GW'(N_CH - 1)) ? '0 : w + 1'b1;
  endfunction

  assign win = pick_winner(req, rr_ptr);
  // The enable is one-hot, so masking selects the granted client's busy
  // without indexing past N_CH when N_CH is not a power of two.
  assign cur_busy = |(ch_busy & enable);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      enable    <= '0;
      grant_idx <= '0;
      active    <= 1'b0;
      timeout   <= 1'b0;
      rr_ptr    <= '0;
      cnt       <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            enable    <= onehot(win);
            grant_idx <= win;
            active    <= 1'b1;
            rr_ptr    <= next_idx(win);
            cnt       <= '0;
            state     <= ARM;
          end
        end
        ARM: begin
          // A busy rising on the expiry cycle still counts as a start.
          if (cur_busy) begin
            state <= RUN;
          end else if (cnt == CW'(START_TIMEOUT - 1)) begin
            timeout <= 1'b1;
            state   <= DRAIN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: begin
          if (!cur_busy) state <= DRAIN;
        end
        DRAIN: begin
          // Hold the grant until the last byte has left the SPI.
          if (!spi_busy) begin
            enable <= '0;
            active <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The mux is driven straight from the enable register, so it follows an
  // asynchronous reset immediately and passes the transmit strobe through
  // in the same cycle.
  always_comb begin
    spi_data     = '0;
    spi_dc       = 1'b0;
    spi_transmit = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (enable[i]) begin
        spi_data     = spi_data | ch_data[i*DATA_W +: DATA_W];
        spi_dc       = spi_dc | ch_dc[i];
        spi_transmit = spi_transmit | ch_transmit[i];
      end
    end
  end

endmodule

// File: tb/tb_tft_bus_arbiter.sv
module tb_tft_bus_arbiter;

  logic        clk;
  logic        rst;
  logic [2:0]  req;
  logic [2:0]  ch_busy;
  logic [23:0] ch_data;
  logic [2:0]  ch_dc;
  logic [2:0]  ch_transmit;
  logic        spi_busy;

  // Index 0: fixed-priority instance, index 1: round-robin instance.
  logic [2:0]  en  [2];
  logic [7:0]  sd  [2];
  logic        dc  [2];
  logic        tx  [2];
  logic [1:0]  gi  [2];
  logic        act [2];
  logic        to  [2];

  int checks = 0;
  int errors = 0;
  int bc [3];

  tft_bus_arbiter #(.N_CH(3), .DATA_W(8), .MODE(0), .START_TIMEOUT(16)) dut0 (
    .clk(clk), .rst(rst), .req(req), .ch_busy(ch_busy), .ch_data(ch_data),
    .ch_dc(ch_dc), .ch_transmit(ch_transmit), .spi_busy(spi_busy),
    .enable(en[0]), .spi_data(sd[0]), .spi_dc(dc[0]), .spi_transmit(tx[0]),
    .grant_idx(gi[0]), .active(act[0]), .timeout(to[0])
  );

  tft_bus_arbiter #(.N_CH(3), .DATA_W(8), .MODE(1), .START_TIMEOUT(16)) dut1 (
    .clk(clk), .rst(rst), .req(req), .ch_busy(ch_busy), .ch_data(ch_data),
    .ch_dc(ch_dc), .ch_transmit(ch_transmit), .spi_busy(spi_busy),
    .enable(en[1]), .spi_data(sd[1]), .spi_dc(dc[1]), .spi_transmit(tx[1]),
    .grant_idx(gi[1]), .active(act[1]), .timeout(to[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference arbitration rule: list channels in priority order and take
  // the first one that requests.
  function automatic int pick(input logic [2:0] r, input int ptr, input int mode);
    int order[$];
    for (int k = 0; k < 3; k++) order.push_back(mode != 0 ? (ptr + k) % 3 : k);
    foreach (order[j]) if (r[order[j]]) return order[j];
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req = '0; ch_busy = '0; ch_data = '0; ch_dc = '0; ch_transmit = '0; spi_busy = 1'b0;
    for (int i = 0; i < 3; i++) bc[i] = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // Emulated clients: after being enabled, a client is busy for 5 cycles.
  // When drop is set, it withdraws its request once it is done.
  task automatic cli_step(input int d, input bit drop);
    for (int i = 0; i < 3; i++) begin
      if (en[d][i]) begin
        bc[i]++;
        ch_busy[i] = (bc[i] >= 1 && bc[i] <= 5);
        if (drop && bc[i] == 6) req[i] = 1'b0;
      end else begin
        bc[i] = 0;
        ch_busy[i] = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req = 3'b111; ch_busy = '0; ch_data = 24'hFFFFFF; ch_dc = '1; ch_transmit = '1; spi_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (en[d] !== 3'b000 || act[d] !== 1'b0 || gi[d] !== 2'd0 || to[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset_state dut%0d en=%b act=%b gi=%0d to=%b want 000/0/0/0", d, en[d], act[d], gi[d], to[d]);
      end
      checks++;
      if (sd[d] !== 8'h00 || dc[d] !== 1'b0 || tx[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset_mux dut%0d data=%h dc=%b tx=%b want 00/0/0", d, sd[d], dc[d], tx[d]);
      end
    end
    req = '0; ch_data = '0; ch_dc = '0; ch_transmit = '0;
    #1 rst = 1'b1;
  endtask

  task automatic test_priority();
    logic [2:0] seq[$];
    logic [2:0] last;
    int gap;
    int mingap;
    do_reset();
    req = 3'b110;
    last = '0; gap = 0; mingap = 99;
    for (int c = 0; c < 100 && seq.size() < 2; c++) begin
      tick();
      if (en[0] != 3'b000 && last == 3'b000) begin
        seq.push_back(en[0]);
        if (seq.size() > 1 && gap < mingap) mingap = gap;
      end
      gap  = (en[0] == 3'b000) ? gap + 1 : 0;
      last = en[0];
      cli_step(0, 1'b1);
    end
    checks++;
    if (seq.size() != 2) begin
      errors++;
      $display("FAIL prio_grants got %0d grants want 2", seq.size());
    end else begin
      checks++;
      if (seq[0] !== 3'b010 || seq[1] !== 3'b100) begin
        errors++;
        $display("FAIL prio_order got %b,%b want 010,100", seq[0], seq[1]);
      end
      checks++;
      if (mingap < 1) begin
        errors++;
        $display("FAIL prio_idle_gap got %0d idle cycles want >=1", mingap);
      end
    end
  endtask

  task automatic test_round_robin();
    int got[$];
    int want[5] = '{0, 1, 2, 0, 1};
    logic [2:0] last;
    do_reset();
    req = 3'b111;
    last = '0;
    for (int c = 0; c < 300 && got.size() < 5; c++) begin
      tick();
      if (en[1] != 3'b000 && last == 3'b000) begin
        got.push_back(int'(gi[1]));
        checks++;
        if (en[1] !== 3'(1 << int'(gi[1]))) begin
          errors++;
          $display("FAIL rr_onehot en=%b gi=%0d want en matching gi", en[1], gi[1]);
        end
      end
      last = en[1];
      cli_step(1, 1'b0);
    end
    checks++;
    if (got.size() != 5) begin
      errors++;
      $display("FAIL rr_grants got %0d grants want 5", got.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (got[i] != want[i]) begin
          errors++;
          $display("FAIL rr_order grant%0d got %0d want %0d", i, got[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    req = 3'b001;
    for (int c = 0; c < 10 && en[0] == 3'b000; c++) tick();
    checks++;
    if (en[0] !== 3'b001) begin
      errors++;
      $display("FAIL to_grant en=%b want 001", en[0]);
    end
    n = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      n++;
      if (to[0] === 1'b1) break;
    end
    checks++;
    if (n != 16 || to[0] !== 1'b1) begin
      errors++;
      $display("FAIL to_latency got %0d cycles (to=%b) want 16", n, to[0]);
    end
    req = '0;
    tick();
    checks++;
    if (to[0] !== 1'b0 || en[0] !== 3'b000) begin
      errors++;
      $display("FAIL to_release to=%b en=%b want 0/000", to[0], en[0]);
    end
  endtask

  task automatic test_drain();
    do_reset();
    req = 3'b010;
    spi_busy = 1'b1;
    for (int c = 0; c < 10 && en[0] == 3'b000; c++) tick();
    ch_busy = 3'b010;
    repeat (3) tick();
    req = '0;
    ch_busy = '0;
    for (int c = 0; c < 7; c++) begin
      tick();
      checks++;
      if (en[0] !== 3'b010) begin
        errors++;
        $display("FAIL drain_hold cycle%0d en=%b want 010", c, en[0]);
      end
    end
    spi_busy = 1'b0;
    tick();
    checks++;
    if (en[0] !== 3'b000 || act[0] !== 1'b0) begin
      errors++;
      $display("FAIL drain_release en=%b act=%b want 000/0", en[0], act[0]);
    end
  endtask

  task automatic test_mux();
    do_reset();
    ch_data = {8'hA5, 8'h3C, 8'h5A};
    ch_dc = 3'b100;
    ch_transmit = 3'b000;
    req = 3'b100;
    #1;
    checks++;
    if (sd[0] !== 8'h00 || dc[0] !== 1'b0) begin
      errors++;
      $display("FAIL mux_idle data=%h dc=%b want 00/0", sd[0], dc[0]);
    end
    for (int c = 0; c < 5 && en[0] == 3'b000; c++) tick();
    checks++;
    if (sd[0] !== 8'hA5 || dc[0] !== 1'b1 || tx[0] !== 1'b0) begin
      errors++;
      $display("FAIL mux_ch2 data=%h dc=%b tx=%b want a5/1/0", sd[0], dc[0], tx[0]);
    end
    ch_transmit = 3'b011;
    ch_data[7:0] = 8'hFF;
    #1;
    checks++;
    if (tx[0] !== 1'b0 || sd[0] !== 8'hA5) begin
      errors++;
      $display("FAIL mux_other tx=%b data=%h want 0/a5", tx[0], sd[0]);
    end
    ch_transmit = 3'b100;
    #1;
    checks++;
    if (tx[0] !== 1'b1) begin
      errors++;
      $display("FAIL mux_tx_pass tx=%b want 1", tx[0]);
    end
    ch_transmit = 3'b000;
    req = '0;
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    req = 3'b001;
    for (int c = 0; c < 5 && en[1] == 3'b000; c++) tick();
    ch_busy = 3'b001;
    ch_transmit = 3'b001;
    repeat (2) tick();
    checks++;
    if (en[1] !== 3'b001 || tx[1] !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre en=%b tx=%b want 001/1", en[1], tx[1]);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (en[1] !== 3'b000 || act[1] !== 1'b0 || tx[1] !== 1'b0 || en[0] !== 3'b000) begin
      errors++;
      $display("FAIL rst_async en=%b act=%b tx=%b en0=%b want 000/0/0/000", en[1], act[1], tx[1], en[0]);
    end
    req = 3'b011;
    ch_busy = '0;
    ch_transmit = '0;
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 5 && en[1] == 3'b000; c++) tick();
    checks++;
    if (en[1] !== 3'b001 || gi[1] !== 2'd0) begin
      errors++;
      $display("FAIL rst_rr_restart en=%b gi=%0d want 001/0", en[1], gi[1]);
    end
    req = '0;
  endtask

  task automatic test_random();
    logic [2:0] pen [2];
    int rr [2];
    int k [2];
    bit nob [2];
    int w [2];
    logic [2:0] dead;
    int ew;
    bit exp_to;
    logic [7:0] exp_sd;
    logic exp_dc;
    logic exp_tx;
    do_reset();
    dead = '0;
    for (int d = 0; d < 2; d++) begin
      pen[d] = '0; rr[d] = 0; k[d] = 0; nob[d] = 1'b0; w[d] = 0;
    end
    for (int c = 0; c < 3000; c++) begin
      if (c % 64 == 0) dead = 3'($urandom) & 3'($urandom);
      req = 3'($urandom);
      for (int i = 0; i < 3; i++) ch_busy[i] = dead[i] ? 1'b0 : 1'($urandom);
      ch_data = 24'($urandom);
      ch_dc = 3'($urandom);
      ch_transmit = 3'($urandom);
      spi_busy = 1'($urandom);
      tick();
      for (int d = 0; d < 2; d++) begin
        if (pen[d] == 3'b000) begin
          if (req != 3'b000) begin
            ew = pick(req, rr[d], d);
            checks++;
            if (en[d] !== 3'(1 << ew) || gi[d] !== 2'(ew) || act[d] !== 1'b1 || to[d] !== 1'b0) begin
              errors++;
              $display("FAIL rand_grant dut%0d cyc%0d req=%b en=%b gi=%0d act=%b want en=%b gi=%0d",
                       d, c, req, en[d], gi[d], act[d], 3'(1 << ew), ew);
            end
            rr[d] = (ew + 1) % 3;
            w[d] = ew;
            k[d] = 0;
            nob[d] = 1'b1;
          end else begin
            checks++;
            if (en[d] !== 3'b000 || act[d] !== 1'b0 || to[d] !== 1'b0) begin
              errors++;
              $display("FAIL rand_idle dut%0d cyc%0d en=%b act=%b to=%b want 000/0/0", d, c, en[d], act[d], to[d]);
            end
          end
        end else begin
          k[d]++;
          if (ch_busy[w[d]]) nob[d] = 1'b0;
          exp_to = (k[d] == 16) && nob[d];
          checks++;
          if (to[d] !== exp_to) begin
            errors++;
            $display("FAIL rand_timeout dut%0d cyc%0d to=%b want %b", d, c, to[d], exp_to);
          end
          checks++;
          if (en[d] == 3'b000) begin
            if (spi_busy !== 1'b0 || act[d] !== 1'b0) begin
              errors++;
              $display("FAIL rand_release dut%0d cyc%0d spi_busy=%b act=%b want release only when spi idle", d, c, spi_busy, act[d]);
            end
          end else if (en[d] !== pen[d] || act[d] !== 1'b1) begin
            errors++;
            $display("FAIL rand_hold dut%0d cyc%0d en=%b act=%b want %b/1", d, c, en[d], act[d], pen[d]);
          end
        end
        exp_sd = (en[d] != 3'b000) ? ch_data[w[d]*8 +: 8] : 8'h00;
        exp_dc = (en[d] != 3'b000) ? ch_dc[w[d]] : 1'b0;
        exp_tx = (en[d] != 3'b000) ? ch_transmit[w[d]] : 1'b0;
        checks++;
        if (sd[d] !== exp_sd || dc[d] !== exp_dc || tx[d] !== exp_tx) begin
          errors++;
          $display("FAIL rand_mux dut%0d cyc%0d data=%h dc=%b tx=%b want %h/%b/%b",
                   d, c, sd[d], dc[d], tx[d], exp_sd, exp_dc, exp_tx);
        end
        pen[d] = en[d];
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    req = '0; ch_busy = '0; ch_data = '0; ch_dc = '0; ch_transmit = '0; spi_busy = 1'b0;
    test_reset();
    test_priority();
    test_round_robin();
    test_timeout();
    test_drain();
    test_mux();
    test_reset_mid_run();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
